// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared types and defaults for the scan chain sequencer
//
// Purpose : state encoding and default chain geometry used by scan_chain_ctrl.
// Contents: DEF_CHAIN_LEN, DEF_CAP_CYC  - default parameter values
//           state_e                     - 3-bit sequencer state encoding
package scan_ctrl_pkg;

    localparam int DEF_CHAIN_LEN = 16;
    localparam int DEF_CAP_CYC   = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SHIFT_OUT = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - load / capture / unload sequencer for one muxed-D scan chain
//
// Purpose : serially loads a pattern (MSB first), applies CAP_CYC functional
//           capture cycles, unloads the chain into a result register and
//           compares it against a masked expected value.
// Ports   : CLK      - clock, shared with the scan chain
//           RN       - asynchronous active-low reset
//           start    - run request, accepted in IDLE only
//           abort    - synchronous abort of a run in progress
//           pat_in   - pattern to load, pat_in[k] lands in cell k
//           exp_in   - expected captured value
//           mask_in  - per-bit compare enable
//           scan_so  - Q of the last chain cell
//           scan_en  - SE of every chain cell (registered)
//           scan_si  - SI of chain cell 0 (registered)
//           busy     - high outside IDLE (registered)
//           done     - one-cycle pulse at the end of a completed run
//           pass     - masked compare result, valid from done
//           result   - unloaded chain content, result[k] = cell k after capture
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CAP_CYC   = DEF_CAP_CYC,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic [CHAIN_LEN-1:0] mask_in,
    input  logic                 scan_so,
    output logic                 scan_en,
    output logic                 scan_si,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] result
);

    // The same counter times both shift phases and the capture phase, so it
    // must also be wide enough for a capture count longer than the chain.
    localparam int CAP_W = $clog2(CAP_CYC + 1);
    localparam int CTR_W = (CNT_W > CAP_W) ? CNT_W : CAP_W;

    localparam logic [CTR_W-1:0] SHIFT_LAST = CTR_W'(CHAIN_LEN - 1);
    localparam logic [CTR_W-1:0] CAP_LAST   = CTR_W'(CAP_CYC - 1);
    localparam logic [CTR_W-1:0] CNT_ONE    = CTR_W'(1);

    state_e               state_q, state_d;
    logic [CTR_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic [CHAIN_LEN-1:0] result_q, result_d;
    logic                 pass_q, pass_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_si_q, scan_si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            exp_q     <= '0;
            mask_q    <= '0;
            sh_q      <= '0;
            result_q  <= '0;
            pass_q    <= 1'b0;
            scan_en_q <= 1'b0;
            scan_si_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            exp_q     <= exp_d;
            mask_q    <= mask_d;
            sh_q      <= sh_d;
            result_q  <= result_d;
            pass_q    <= pass_d;
            scan_en_q <= scan_en_d;
            scan_si_q <= scan_si_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The chain-facing outputs are registered, so every decision here is made
    // one cycle ahead: the values computed below are what the chain sees in
    // the cycle after the coming edge, i.e. they follow state_d, not state_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        exp_d     = exp_q;
        mask_d    = mask_q;
        sh_d      = sh_q;
        result_d  = result_q;
        pass_d    = pass_q;
        scan_en_d = 1'b0;
        scan_si_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // pat_q is kept pre-shifted: its MSB is always the next
                    // bit to present, so no variable index is needed.
                    pat_d     = {pat_in[CHAIN_LEN-2:0], 1'b0};
                    exp_d     = exp_in;
                    mask_d    = mask_in;
                    sh_d      = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT_IN;
                    scan_en_d = 1'b1;
                    scan_si_d = pat_in[CHAIN_LEN-1];
                end
            end

            ST_SHIFT_IN: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    scan_en_d = 1'b1;
                    scan_si_d = pat_q[CHAIN_LEN-1];
                    pat_d     = {pat_q[CHAIN_LEN-2:0], 1'b0};
                end
            end

            ST_CAPTURE: begin
                if (cnt_q == CAP_LAST) begin
                    cnt_d     = '0;
                    state_d   = ST_SHIFT_OUT;
                    scan_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_SHIFT_OUT: begin
                // Unload into a private shift register; result/pass are only
                // committed on the final edge so an abort leaves them intact.
                sh_d = {sh_q[CHAIN_LEN-2:0], scan_so};
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                    result_d = sh_d;
                    pass_d   = ~|((sh_d ^ exp_q) & mask_q);
                    done_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    scan_en_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            sh_d      = sh_q;
            result_d  = result_q;
            pass_d    = pass_q;
            scan_en_d = 1'b0;
            scan_si_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    assign busy_d  = (state_d != ST_IDLE);

    assign scan_en = scan_en_q;
    assign scan_si = scan_si_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign result  = result_q;

endmodule
